// File: rtl/conv2_seq_ctrl.sv
// conv2_seq_ctrl: loads the 225 conv2 filter bytes, then streams every 5x5x3 window of the feature map.
// Optional macro CONV2_SEQ_PERF_EN adds o_cycle_cnt, the number of busy cycles of the last pass.
module conv2_seq_ctrl #(
    parameter int IMG_W  = 14,
    parameter int IMG_H  = 14,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_w_rd,
    output logic [7:0]        o_w_addr,
    input  logic [7:0]        i_w_data,
    output logic              o_weight_valid,
    output logic [7:0]        o_filter,
    input  logic              i_weight_done,
    output logic              o_fm_rd,
    output logic [ADDR_W-1:0] o_fm_addr,
    input  logic [15:0]       i_fm_ch0,
    input  logic [15:0]       i_fm_ch1,
    input  logic [15:0]       i_fm_ch2,
    output logic              o_conv_valid,
    output logic [15:0]       o_data_ch0,
    output logic [15:0]       o_data_ch1,
    output logic [15:0]       o_data_ch2,
    input  logic              i_conv2_valid
`ifdef CONV2_SEQ_PERF_EN
    ,
    output logic [31:0]       o_cycle_cnt
`endif
);
    localparam int K     = 5;
    localparam int OUT_W = IMG_W - 4;
    localparam int OUT_H = IMG_H - 4;
    localparam int N_WGT = 225;
    localparam int N_POS = OUT_W * OUT_H;
    localparam int PW    = $clog2(N_POS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_WAIT_W = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              w_rd_q, w_rd_d;
    logic [7:0]        w_addr_q, w_addr_d;
    logic              fm_rd_q, fm_rd_d;
    logic [ADDR_W-1:0] fm_addr_q, fm_addr_d;
    logic [2:0]        kx_q, kx_d, ky_q, ky_d;
    logic [ADDR_W-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d, row_base_q, row_base_d;
    logic [PW-1:0]     out_cnt_q, out_cnt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              w_rd_p_q, fm_rd_p_q, wv_q, cv_q;
    logic [7:0]        filter_q;
    logic [15:0]       data0_q, data1_q, data2_q;

    // Next state, address walk and output counter
    always_comb begin
        state_d    = state_q;
        w_rd_d     = 1'b0;
        w_addr_d   = w_addr_q;
        fm_rd_d    = 1'b0;
        fm_addr_d  = fm_addr_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        win_base_d = win_base_q;
        row_base_d = row_base_q;
        out_cnt_d  = out_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    out_cnt_d = {PW{1'b0}};
                    if (i_weight_done) begin
                        state_d = S_STREAM;
                        fm_rd_d = 1'b1;
                    end else begin
                        state_d  = S_LOAD_W;
                        w_rd_d   = 1'b1;
                        w_addr_d = 8'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_W: begin
                if (w_addr_q == 8'(N_WGT - 1)) begin
                    state_d = S_WAIT_W;
                end else begin
                    w_rd_d   = 1'b1;
                    w_addr_d = w_addr_q + 8'd1;
                end
            end
            S_WAIT_W: begin
                if (i_weight_done) begin
                    state_d = S_STREAM;
                    fm_rd_d = 1'b1;
                end else begin
                    state_d = S_WAIT_W;
                end
            end
            S_STREAM: begin
                // Counters always describe the address currently on o_fm_addr; all return to 0 at the end.
                fm_rd_d = 1'b1;
                if (kx_q != 3'd4) begin
                    kx_d      = kx_q + 3'd1;
                    fm_addr_d = fm_addr_q + ADDR_W'(1);
                end else if (ky_q != 3'd4) begin
                    kx_d       = 3'd0;
                    ky_d       = ky_q + 3'd1;
                    row_base_d = row_base_q + ADDR_W'(IMG_W);
                    fm_addr_d  = row_base_q + ADDR_W'(IMG_W);
                end else if (ox_q != ADDR_W'(OUT_W - 1)) begin
                    kx_d       = 3'd0;
                    ky_d       = 3'd0;
                    ox_d       = ox_q + ADDR_W'(1);
                    win_base_d = win_base_q + ADDR_W'(1);
                    row_base_d = win_base_q + ADDR_W'(1);
                    fm_addr_d  = win_base_q + ADDR_W'(1);
                end else if (oy_q != ADDR_W'(OUT_H - 1)) begin
                    kx_d       = 3'd0;
                    ky_d       = 3'd0;
                    ox_d       = {ADDR_W{1'b0}};
                    oy_d       = oy_q + ADDR_W'(1);
                    win_base_d = win_base_q + ADDR_W'(K);
                    row_base_d = win_base_q + ADDR_W'(K);
                    fm_addr_d  = win_base_q + ADDR_W'(K);
                end else begin
                    fm_rd_d    = 1'b0;
                    state_d    = S_DRAIN;
                    kx_d       = 3'd0;
                    ky_d       = 3'd0;
                    ox_d       = {ADDR_W{1'b0}};
                    oy_d       = {ADDR_W{1'b0}};
                    win_base_d = {ADDR_W{1'b0}};
                    row_base_d = {ADDR_W{1'b0}};
                    fm_addr_d  = {ADDR_W{1'b0}};
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == PW'(N_POS)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if ((state_q == S_STREAM || state_q == S_DRAIN) && i_conv2_valid && out_cnt_q != PW'(N_POS)) begin
            out_cnt_d = out_cnt_q + PW'(1);
        end else begin
            out_cnt_d = out_cnt_d;
        end
        busy_d = (state_d == S_LOAD_W) || (state_d == S_WAIT_W) ||
                 (state_d == S_STREAM) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Control registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            w_rd_q     <= 1'b0;
            w_addr_q   <= 8'd0;
            fm_rd_q    <= 1'b0;
            fm_addr_q  <= {ADDR_W{1'b0}};
            kx_q       <= 3'd0;
            ky_q       <= 3'd0;
            ox_q       <= {ADDR_W{1'b0}};
            oy_q       <= {ADDR_W{1'b0}};
            win_base_q <= {ADDR_W{1'b0}};
            row_base_q <= {ADDR_W{1'b0}};
            out_cnt_q  <= {PW{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_rd_q     <= w_rd_d;
            w_addr_q   <= w_addr_d;
            fm_rd_q    <= fm_rd_d;
            fm_addr_q  <= fm_addr_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            win_base_q <= win_base_d;
            row_base_q <= row_base_d;
            out_cnt_q  <= out_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Memory read data lands one cycle after the strobe; register it toward conv2_layer
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            w_rd_p_q  <= 1'b0;
            fm_rd_p_q <= 1'b0;
            wv_q      <= 1'b0;
            cv_q      <= 1'b0;
            filter_q  <= 8'd0;
            data0_q   <= 16'd0;
            data1_q   <= 16'd0;
            data2_q   <= 16'd0;
        end else begin
            w_rd_p_q  <= w_rd_q;
            fm_rd_p_q <= fm_rd_q;
            wv_q      <= w_rd_p_q;
            cv_q      <= fm_rd_p_q;
            filter_q  <= w_rd_p_q ? i_w_data : filter_q;
            data0_q   <= fm_rd_p_q ? i_fm_ch0 : data0_q;
            data1_q   <= fm_rd_p_q ? i_fm_ch1 : data1_q;
            data2_q   <= fm_rd_p_q ? i_fm_ch2 : data2_q;
        end
    end

`ifdef CONV2_SEQ_PERF_EN
    logic [31:0] cyc_q;

    // Busy-cycle counter: cleared when a pass is accepted, holds while idle
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cyc_q <= 32'd0;
        end else if (state_q == S_IDLE && i_start) begin
            cyc_q <= 32'd0;
        end else if (busy_q) begin
            cyc_q <= cyc_q + 32'd1;
        end else begin
            cyc_q <= cyc_q;
        end
    end

    assign o_cycle_cnt = cyc_q;
`endif

    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_w_rd         = w_rd_q;
    assign o_w_addr       = w_addr_q;
    assign o_fm_rd        = fm_rd_q;
    assign o_fm_addr      = fm_addr_q;
    assign o_weight_valid = wv_q;
    assign o_filter       = filter_q;
    assign o_conv_valid   = cv_q;
    assign o_data_ch0     = data0_q;
    assign o_data_ch1     = data1_q;
    assign o_data_ch2     = data2_q;
endmodule

// File: tb/tb_conv2_seq_ctrl.sv
// Self-checking bench for conv2_seq_ctrl on a 6x6 map with random ROM/feature-map contents.
// Define CONV2_SEQ_PERF_EN to also check o_cycle_cnt.
module tb_conv2_seq_ctrl;
    localparam int W = 6, H = 6, AW = 8;
    localparam int OW = W - 4, OH = H - 4, NPOS = OW * OH, NW = 225, NRD = 25 * NPOS;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_rst, i_start, i_weight_done, i_conv2_valid;
    logic o_busy, o_done, o_w_rd, o_weight_valid, o_fm_rd, o_conv_valid;
    logic [7:0] o_w_addr, i_w_data, o_filter;
    logic [AW-1:0] o_fm_addr;
    logic [15:0] i_fm_ch0, i_fm_ch1, i_fm_ch2, o_data_ch0, o_data_ch1, o_data_ch2;
`ifdef CONV2_SEQ_PERF_EN
    logic [31:0] o_cycle_cnt;
`endif

    conv2_seq_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_w_rd(o_w_rd), .o_w_addr(o_w_addr), .i_w_data(i_w_data),
        .o_weight_valid(o_weight_valid), .o_filter(o_filter), .i_weight_done(i_weight_done),
        .o_fm_rd(o_fm_rd), .o_fm_addr(o_fm_addr),
        .i_fm_ch0(i_fm_ch0), .i_fm_ch1(i_fm_ch1), .i_fm_ch2(i_fm_ch2),
        .o_conv_valid(o_conv_valid), .o_data_ch0(o_data_ch0), .o_data_ch1(o_data_ch1),
        .o_data_ch2(o_data_ch2), .i_conv2_valid(i_conv2_valid)
`ifdef CONV2_SEQ_PERF_EN
        , .o_cycle_cnt(o_cycle_cnt)
`endif
    );

    logic [7:0]  rom [0:NW-1];
    logic [15:0] fm0 [0:W*H-1];
    logic [15:0] fm1 [0:W*H-1];
    logic [15:0] fm2 [0:W*H-1];

    // Synchronous-read memories
    always @(posedge i_clk) begin
        if (o_w_rd) i_w_data <= rom[o_w_addr];
        if (o_fm_rd) begin
            i_fm_ch0 <= fm0[o_fm_addr];
            i_fm_ch1 <= fm1[o_fm_addr];
            i_fm_ch2 <= fm2[o_fm_addr];
        end
    end

    // conv2_layer stand-in: weight_done after 225 filters, one result pulse a few cycles after each window
    logic wdone_q;
    int   wv_seen, win_pos;
    logic [3:0] win_sr;
    always @(posedge i_clk) begin
        if (!i_rst) begin
            wdone_q <= 1'b0; wv_seen <= 0; win_pos <= 0; win_sr <= 4'd0;
        end else begin
            if (o_weight_valid) begin
                wv_seen <= wv_seen + 1;
                if (wv_seen == NW - 1) wdone_q <= 1'b1;
            end
            win_sr <= {win_sr[2:0], (o_conv_valid && win_pos == 24)};
            if (o_conv_valid) win_pos <= (win_pos == 24) ? 0 : win_pos + 1;
        end
    end
    assign i_weight_done = wdone_q;
    assign i_conv2_valid = win_sr[3];

    int vectors = 0, miscompares = 0;
    int cyc = 0, pulses, busy_cyc, done_cnt, pulses_at_done;
    logic busy_at_done;
    int w_addr_rec[$], w_cyc_rec[$], wv_cyc_rec[$], fm_addr_rec[$], fm_cyc_rec[$], cv_cyc_rec[$];
    logic [7:0]  filt_rec[$];
    logic [47:0] cv_data_rec[$];
    int exp_addr[$];

    task automatic clear_rec();
        w_addr_rec.delete(); w_cyc_rec.delete(); wv_cyc_rec.delete(); filt_rec.delete();
        fm_addr_rec.delete(); fm_cyc_rec.delete(); cv_cyc_rec.delete(); cv_data_rec.delete();
        pulses = 0; busy_cyc = 0; done_cnt = 0; pulses_at_done = -1; busy_at_done = 1'b0;
    endtask

    task automatic step();
        @(negedge i_clk);
        cyc++;
        if (o_w_rd === 1'b1) begin w_addr_rec.push_back(int'(o_w_addr)); w_cyc_rec.push_back(cyc); end
        if (o_weight_valid === 1'b1) begin filt_rec.push_back(o_filter); wv_cyc_rec.push_back(cyc); end
        if (o_fm_rd === 1'b1) begin fm_addr_rec.push_back(int'(o_fm_addr)); fm_cyc_rec.push_back(cyc); end
        if (o_conv_valid === 1'b1) begin
            cv_cyc_rec.push_back(cyc);
            cv_data_rec.push_back({o_data_ch2, o_data_ch1, o_data_ch0});
        end
        if (i_conv2_valid === 1'b1) pulses++;
        if (o_busy === 1'b1) busy_cyc++;
        if (o_done === 1'b1) begin done_cnt++; pulses_at_done = pulses; busy_at_done = o_busy; end
    endtask

    task automatic run_to_done(input int target, input int budget);
        for (int n = 0; n < budget && done_cnt < target; n++) step();
        repeat (3) step();
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NW; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < W * H; i++) begin
            fm0[i] = 16'($urandom); fm1[i] = 16'($urandom); fm2[i] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_start = 1'b0;
        repeat (3) step();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", o_done); end
        vectors++; if ({o_w_rd, o_w_addr} !== 9'd0) begin miscompares++; $display("FAIL reset_w: got %h want 0", {o_w_rd, o_w_addr}); end
        vectors++; if ({o_fm_rd, o_fm_addr} !== 9'd0) begin miscompares++; $display("FAIL reset_fm: got %h want 0", {o_fm_rd, o_fm_addr}); end
        vectors++; if ({o_weight_valid, o_filter, o_conv_valid} !== 10'd0) begin miscompares++; $display("FAIL reset_wv_cv: got %h want 0", {o_weight_valid, o_filter, o_conv_valid}); end
        vectors++; if ({o_data_ch2, o_data_ch1, o_data_ch0} !== 48'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {o_data_ch2, o_data_ch1, o_data_ch0}); end
        i_rst = 1'b1;
        step();
    endtask

    task automatic test_first_pass();
        int errs;
        clear_rec();
        i_start = 1'b1; step(); i_start = 1'b0;
        run_to_done(1, 3000);
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL first_done_count: got %0d want 1", done_cnt); end
        vectors++; if (w_addr_rec.size() !== NW) begin miscompares++; $display("FAIL w_rd_count: got %0d want %0d", w_addr_rec.size(), NW); end
        vectors++; if (filt_rec.size() !== NW) begin miscompares++; $display("FAIL weight_valid_count: got %0d want %0d", filt_rec.size(), NW); end
        errs = 0;
        for (int i = 0; i < NW && i < w_addr_rec.size() && i < filt_rec.size(); i++) begin
            if (w_addr_rec[i] != i || filt_rec[i] !== rom[i] || wv_cyc_rec[i] != w_cyc_rec[i] + 2 ||
                w_cyc_rec[i] != w_cyc_rec[0] + i) errs++;
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL weight_order: %0d bad entries, want 0", errs); end
        vectors++; if (fm_addr_rec.size() !== NRD) begin miscompares++; $display("FAIL fm_rd_count: got %0d want %0d", fm_addr_rec.size(), NRD); end
        vectors++; if (cv_cyc_rec.size() !== NRD) begin miscompares++; $display("FAIL conv_valid_count: got %0d want %0d", cv_cyc_rec.size(), NRD); end
        errs = 0;
        for (int i = 0; i < NRD && i < fm_addr_rec.size() && i < cv_cyc_rec.size(); i++) begin
            if (fm_addr_rec[i] != exp_addr[i] || fm_cyc_rec[i] != fm_cyc_rec[0] + i ||
                cv_cyc_rec[i] != fm_cyc_rec[i] + 2 ||
                cv_data_rec[i] !== {fm2[exp_addr[i]], fm1[exp_addr[i]], fm0[exp_addr[i]]}) errs++;
        end
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL stream_addr_data: %0d bad reads, want 0", errs); end
        vectors++; if (pulses_at_done !== NPOS) begin miscompares++; $display("FAIL done_after_results: got %0d want %0d", pulses_at_done, NPOS); end
        vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b want 0", busy_at_done); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_pass: got %b want 0", o_busy); end
`ifdef CONV2_SEQ_PERF_EN
        vectors++; if (o_cycle_cnt !== 32'(busy_cyc) || busy_cyc < 325) begin
            miscompares++; $display("FAIL cycle_cnt: got %0d want %0d (>=325)", o_cycle_cnt, busy_cyc);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int errs; bit restarted;
        clear_rec();
        i_start = 1'b1; step();
        vectors++; if ({o_fm_rd, o_fm_addr, o_w_rd} !== {1'b1, 8'd0, 1'b0}) begin
            miscompares++; $display("FAIL skip_load_first_read: got rd=%b addr=%0d wrd=%b want 1/0/0", o_fm_rd, o_fm_addr, o_w_rd);
        end
        for (int n = 0; n < 500 && done_cnt < 1; n++) step();
        restarted = 1'b0;
        for (int n = 0; n < 4 && !restarted; n++) begin step(); if (o_busy === 1'b1) restarted = 1'b1; end
        i_start = 1'b0;
        run_to_done(2, 500);
        vectors++; if (restarted !== 1'b1) begin miscompares++; $display("FAIL held_start_restart: got %b want 1", restarted); end
        vectors++; if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
        vectors++; if (filt_rec.size() + w_addr_rec.size() !== 0) begin miscompares++; $display("FAIL b2b_reload: got %0d weight events want 0", filt_rec.size() + w_addr_rec.size()); end
        vectors++; if (fm_addr_rec.size() !== 2 * NRD) begin miscompares++; $display("FAIL b2b_reads: got %0d want %0d", fm_addr_rec.size(), 2 * NRD); end
        errs = 0;
        for (int i = 0; i < fm_addr_rec.size() && i < 2 * NRD; i++) if (fm_addr_rec[i] != exp_addr[i % NRD]) errs++;
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL b2b_addr: %0d bad, want 0", errs); end
    endtask

    task automatic test_start_mid_stream();
        clear_rec();
        i_start = 1'b1; step(); i_start = 1'b0;
        for (int n = 0; n < 200 && fm_addr_rec.size() < 30; n++) step();
        i_start = 1'b1; step(); i_start = 1'b0;
        run_to_done(1, 500);
        repeat (4) step();
        vectors++; if (fm_addr_rec.size() !== NRD) begin miscompares++; $display("FAIL mid_start_reads: got %0d want %0d", fm_addr_rec.size(), NRD); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL mid_start_done: got %0d want 1", done_cnt); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL mid_start_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        clear_rec();
        i_start = 1'b1; step(); i_start = 1'b0;
        for (int n = 0; n < 200 && fm_addr_rec.size() < 50; n++) step();
        i_rst = 1'b0; step();
        vectors++; if ({o_busy, o_done, o_fm_rd, o_conv_valid, o_w_rd, o_weight_valid} !== 6'd0) begin
            miscompares++; $display("FAIL abort_ctrl: got %b want 000000", {o_busy, o_done, o_fm_rd, o_conv_valid, o_w_rd, o_weight_valid});
        end
        vectors++; if ({o_fm_addr, o_w_addr, o_filter, o_data_ch2, o_data_ch1, o_data_ch0} !== 72'd0) begin
            miscompares++; $display("FAIL abort_data: got %h want 0", {o_fm_addr, o_w_addr, o_filter, o_data_ch2, o_data_ch1, o_data_ch0});
        end
        i_rst = 1'b1;
        repeat (8) step();
        vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
        vectors++; if ({o_busy, o_fm_rd} !== 2'b00) begin miscompares++; $display("FAIL abort_idle: got %b want 00", {o_busy, o_fm_rd}); end
    endtask

    task automatic test_reload_after_reset();
        int errs;
        randomize_mem();
        clear_rec();
        i_start = 1'b1; step(); i_start = 1'b0;
        run_to_done(1, 3000);
        vectors++; if (filt_rec.size() !== NW) begin miscompares++; $display("FAIL reload_count: got %0d want %0d", filt_rec.size(), NW); end
        errs = 0;
        for (int i = 0; i < filt_rec.size() && i < NW; i++) if (filt_rec[i] !== rom[i]) errs++;
        vectors++; if (errs !== 0) begin miscompares++; $display("FAIL reload_filters: %0d bad, want 0", errs); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL reload_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        i_rst = 1'b0; i_start = 1'b0;
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++)
                for (int ky = 0; ky < 5; ky++)
                    for (int kx = 0; kx < 5; kx++)
                        exp_addr.push_back((oy + ky) * W + (ox + kx));
        randomize_mem();
        test_reset();
        test_first_pass();
        test_back_to_back();
        test_start_mid_stream();
        test_reset_mid();
        test_reload_after_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
